// File: rtl/det_sched.sv
// Round-robin scheduler sharing one serial sequence detector among NREQ requesters.
// Each granted frame is shifted MSB-first into the detector and reported as hit/miss.
module det_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned FRAME = 8,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*FRAME-1:0] data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  busy_o,
    output logic                  det_rst_n_o,
    output logic                  det_w_o,
    input  logic                  det_out_i,
    output logic                  done_o,
    output logic [IDW-1:0]        done_id_o,
    output logic                  hit_o,
    output logic [7:0]            hit_cnt_o
);

    localparam int unsigned CW   = $clog2(FRAME);
    localparam int unsigned CNTW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_REPORT
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    last_id_q, last_id_d;
    logic [FRAME-1:0]  sr_q, sr_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic              sticky_q, sticky_d;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              det_rst_n_q, det_rst_n_d;
    logic              det_w_q, det_w_d;
    logic              done_q, done_d;
    logic [IDW-1:0]    done_id_q, done_id_d;
    logic              hit_q, hit_d;
    logic [CNTW-1:0]   hit_cnt_q, hit_cnt_d;

    logic [FRAME-1:0]  words [NREQ];
    logic              pick_vld;
    logic [IDW-1:0]    pick_id;
    logic [IDW-1:0]    cand;
    logic              hit_now;

    // Split the flat data bus into per-requester words.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            words[i] = data_i[i*FRAME +: FRAME];
        end
    end

    // Cyclic scan starting just after the last served requester.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_id_q) + k) % NREQ);
            if (!pick_vld && req_i[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign hit_now = sticky_q | det_out_i;

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        sticky_d    = sticky_q;
        gnt_d       = '0;
        busy_d      = 1'b0;
        det_rst_n_d = 1'b1;
        det_w_d     = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        hit_d       = hit_q;
        hit_cnt_d   = hit_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d     = S_CLR;
                    last_id_d   = pick_id;
                    sr_d        = words[pick_id];
                    sticky_d    = 1'b0;
                    gnt_d       = NREQ'(1) << pick_id;
                    det_rst_n_d = 1'b0;
                end
            end
            S_CLR: begin
                state_d  = S_SHIFT;
                bitcnt_d = '0;
                det_w_d  = sr_q[FRAME-1];
                sr_d     = sr_q << 1;
            end
            S_SHIFT: begin
                // The first shift cycle still sees the detector coming out of clear.
                if (bitcnt_q != '0) begin
                    sticky_d = hit_now;
                end
                if (bitcnt_q == CW'(FRAME-1)) begin
                    state_d = S_DRAIN;
                end else begin
                    bitcnt_d = bitcnt_q + CW'(1);
                    det_w_d  = sr_q[FRAME-1];
                    sr_d     = sr_q << 1;
                end
            end
            S_DRAIN: begin
                state_d   = S_REPORT;
                sticky_d  = hit_now;
                done_d    = 1'b1;
                done_id_d = last_id_q;
                hit_d     = hit_now;
                if (hit_now && (hit_cnt_q != {CNTW{1'b1}})) begin
                    hit_cnt_d = hit_cnt_q + CNTW'(1);
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            last_id_q   <= IDW'(NREQ-1);
            sr_q        <= '0;
            bitcnt_q    <= '0;
            sticky_q    <= 1'b0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            det_rst_n_q <= 1'b0;
            det_w_q     <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            hit_q       <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            sticky_q    <= sticky_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            det_rst_n_q <= det_rst_n_d;
            det_w_q     <= det_w_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            hit_q       <= hit_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;
    assign det_rst_n_o = det_rst_n_q;
    assign det_w_o     = det_w_q;
    assign done_o      = done_q;
    assign done_id_o   = done_id_q;
    assign hit_o       = hit_q;
    assign hit_cnt_o   = hit_cnt_q;

endmodule

// File: tb/tb_det_sched.sv
// Bench for det_sched: four-ones detector model, frame-level reference model,
// directed scenarios plus randomized request traffic.
module tb_det_sched;

    localparam int NREQ  = 4;
    localparam int FRAME = 8;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*FRAME-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  det_rst_n;
    logic                  det_w;
    logic                  det_out = 1'b0;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic                  hit;
    logic [7:0]            hit_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int tcyc   = 0;
    bit auto_drop = 1'b1;

    det_sched #(.NREQ(NREQ), .FRAME(FRAME)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .data_i      (data),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .det_rst_n_o (det_rst_n),
        .det_w_o     (det_w),
        .det_out_i   (det_out),
        .done_o      (done),
        .done_id_o   (done_id),
        .hit_o       (hit),
        .hit_cnt_o   (hit_cnt)
    );

    always #5 clk = ~clk;

    // Detector: output rises on the edge after four consecutive ones.
    int run_ones = 0;
    always @(posedge clk) begin
        if (det_rst_n !== 1'b1) begin
            run_ones <= 0;
            det_out  <= 1'b0;
        end else if (det_w === 1'b1) begin
            run_ones <= (run_ones < 4) ? run_ones + 1 : 4;
            det_out  <= (run_ones >= 3);
        end else begin
            run_ones <= 0;
            det_out  <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit has_run4(input logic [FRAME-1:0] w);
        int r = 0;
        for (int b = FRAME - 1; b >= 0; b--) begin
            r = w[b] ? r + 1 : 0;
            if (r >= 4) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Frame-level reference: m_off is the cycle offset from arbitration (0 = idle).
    bit               m_rstp = 1'b1;
    int               m_off  = 0;
    int               m_id   = 0;
    logic [FRAME-1:0] m_word = '0;
    bit               m_hit  = 1'b0;
    int               m_last = NREQ - 1;
    int               m_cnt  = 0;

    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] e_gnt;
        logic            e_busy, e_drn, e_w, e_done;
        int              pick;
        if (m_rstp) begin
            e_gnt = '0; e_busy = 1'b0; e_drn = 1'b0; e_w = 1'b0; e_done = 1'b0;
        end else begin
            e_gnt  = (m_off == 1) ? NREQ'(1) << m_id : '0;
            e_busy = (m_off != 0);
            e_drn  = (m_off != 1);
            e_w    = (m_off >= 2 && m_off <= FRAME + 1) ? m_word[FRAME + 1 - m_off] : 1'b0;
            e_done = (m_off == FRAME + 3);
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("det_rst_n", 32'(det_rst_n), 32'(e_drn));
        chk("det_w", 32'(det_w), 32'(e_w));
        chk("done", 32'(done), 32'(e_done));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
        if (m_rstp) begin
            chk("rst_done_id", 32'(done_id), 32'd0);
            chk("rst_hit", 32'(hit), 32'd0);
        end else if (e_done) begin
            chk("done_id", 32'(done_id), 32'(m_id));
            chk("hit", 32'(hit), 32'(m_hit));
        end

        if (rst) begin
            m_rstp = 1'b1; m_off = 0; m_last = NREQ - 1; m_cnt = 0;
        end else begin
            m_rstp = 1'b0;
            if (m_off == 0) begin
                pick = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (pick < 0 && req[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
                end
                if (pick >= 0) begin
                    m_id = pick; m_last = pick; m_off = 1;
                    m_word = data[pick*FRAME +: FRAME];
                    m_hit  = has_run4(m_word);
                end
            end else if (m_off == FRAME + 3) begin
                m_off = 0;
            end else begin
                m_off++;
                if (m_off == FRAME + 3 && m_hit && m_cnt < 255) m_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic wait_done(output int id, output int at);
        int n = 0;
        id = -1; at = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 40);
        if (done !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_done: no done within %0d cycles at %0t", n, $time);
        end else begin
            id = int'(done_id); at = tcyc;
        end
    endtask

    // Drive one frame from requester i starting in an idle cycle; checks literal expectations.
    task automatic one_frame(input string nm, input int i, input logic [FRAME-1:0] w,
                             input int exp_hit, input int exp_cnt);
        logic [FRAME-1:0] stream;
        stream = '0;
        data[i*FRAME +: FRAME] = w;
        req[i] = 1'b1;
        tick();
        chk({nm, "_gnt"}, 32'(gnt), 32'(1 << i));
        for (int k = 0; k < FRAME; k++) begin
            tick();
            stream = {stream[FRAME-2:0], det_w};
        end
        chk({nm, "_stream"}, 32'(stream), 32'(w));
        tick();
        tick();
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_done_id"}, 32'(done_id), 32'(i));
        chk({nm, "_hit"}, 32'(hit), 32'(exp_hit));
        chk({nm, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_cnt));
        tick();
    endtask

    initial begin : stim
        int ids[4];
        int ats[4];
        int ndone;
        rst = 1'b1; req = '1; data = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_det_rst_n", 32'(det_rst_n), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'b0001);

        for (int k = 0; k < 4; k++) wait_done(ids[k], ats[k]);
        for (int k = 0; k < 4; k++) chk("fair_order", 32'(ids[k]), 32'(k));
        for (int k = 1; k < 4; k++) chk("fair_period", 32'(ats[k] - ats[k-1]), 32'd12);
        repeat (3) tick();

        one_frame("hit", 2, 8'b0111_1000, 1, 1);
        one_frame("miss", 1, 8'b1101_1011, 0, 1);
        one_frame("tail", 0, 8'b0000_1111, 1, 2);

        data[3*FRAME +: FRAME] = 8'hFF;
        req[3] = 1'b1;
        tick();
        chk("mrst_gnt", 32'(gnt), 32'b1000);
        repeat (4) tick();
        chk("mrst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_hit_cnt", 32'(hit_cnt), 32'd0);
        rst = 1'b0;
        ndone = 0;
        repeat (14) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("mrst_nodone", 32'(ndone), 32'd0);
        one_frame("post_rst", 0, 8'b1111_0000, 1, 1);

        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                data[i*FRAME +: FRAME] = FRAME'($urandom);
                if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
            end
            rst = ($urandom_range(499) == 0);
        end

        rst = 1'b1;
        tick();
        rst = 1'b0; auto_drop = 1'b0; req = '1; data = '1;
        repeat (265 * 12 + 5) tick();
        chk("sat_hit_cnt", 32'(hit_cnt), 32'd255);
        req = '0;
        repeat (15) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/det_sched.md
# det_sched

Round-robin scheduler that shares one serial sequence-detector FSM among NREQ requesters. Each requester presents a FRAME-bit word. The scheduler grants one requester at a time and clears the detector. It then shifts the word into the detector MSB-first, watches the detector output, and reports per-frame hit/miss plus a running hit count. It sits between the requesting blocks and the detector instance, and owns the detector's reset and input bit.

## Interface
- NREQ, 4: number of requesters; supported values are 2 to 8.
- FRAME, 8: bits per frame; must be 2 or more.
- IDW, $clog2(NREQ): width of the requester index.
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; held high until the matching gnt bit.
- data  in  NREQ*FRAME  frame words; requester i owns bits [i*FRAME +: FRAME].
- gnt  out  NREQ  one-hot, single-cycle grant; the requester's data was captured at that edge.
- busy  out  1  high in every state except IDLE.
- det_rst_n  out  1  active-low clear to the detector.
- det_w  out  1  serial bit to the detector.
- det_out  in  1  detector Moore output.
- done  out  1  single-cycle pulse at the end of a frame.
- done_id  out  IDW  index of the requester just served; valid while done is high.
- hit  out  1  1 if the detector fired during the frame; valid while done is high.
- hit_cnt  out  8  total number of frames with a hit, saturating at 255.

## Operation
- All outputs are registered.
- States: IDLE, CLR, SHIFT, DRAIN, REPORT.
- IDLE:
  - If req is nonzero, choose the first set bit, scanning cyclically from last_id+1.
  - Load data[id] into the shift register, set last_id=id, and go to CLR.
  - If req is zero, stay in IDLE.
- CLR, 1 cycle: gnt[id]=1, det_rst_n=0, det_w=0, sticky hit flag cleared. Next state is SHIFT with bitcnt=0.
- SHIFT, FRAME cycles:
  - det_w = shift register MSB; shift left each cycle; bitcnt increments.
  - Leave for DRAIN when bitcnt==FRAME-1.
- DRAIN, 1 cycle: det_w=0.
- Hit sampling: the sticky hit flag ORs in det_out on every SHIFT cycle except the first, and on the DRAIN cycle. This covers the detector response to every shifted bit.
- REPORT, 1 cycle: done=1, done_id=id, hit=sticky flag. If the flag is set and hit_cnt<255, hit_cnt increments. Next state is IDLE.
- Outside the stated states: gnt=0, det_rst_n=1, det_w=0, done=0.
- req changes while busy are ignored; arbitration happens only in IDLE.
- A requester that drops req before its grant is not served.
- Round-robin: the requester granted last has the lowest priority at the next arbitration.

## Timing
- Values while rst is high and on the first cycle after it:
  - State IDLE; gnt=0, busy=0, det_w=0, done=0, hit=0, done_id=0, hit_cnt=0.
  - last_id=NREQ-1, so requester 0 has top priority first.
  - det_rst_n=0 while rst is high, so reset is forwarded to the detector.
- Latency: if req is seen in IDLE at cycle t:
  - gnt at t+1;
  - first det_w bit at t+2;
  - last bit at t+1+FRAME;
  - done at t+3+FRAME, which is t+11 for FRAME=8.
- Throughput: at least one IDLE cycle between frames, so the minimum frame period is FRAME+4 cycles (12 for FRAME=8).
- rst asserted mid-frame: at the next edge the block returns to IDLE with all reset values. No done is produced and hit_cnt is cleared.
- Requests arriving in the REPORT cycle are arbitrated in the following IDLE cycle.

## Test plan
Bench model of the detector: det_out goes to 1 on the edge after four consecutive 1s; it is cleared by det_rst_n=0. Parameters are the defaults.
- Reset: hold rst for 2 cycles with req=4'hF -> gnt=0, busy=0, det_rst_n=0, hit_cnt=0. The first grant after release is gnt=4'b0001.
- Single hit: req[2]=1, data[2]=8'b0111_1000 -> gnt=4'b0100 one cycle after req, det_w stream 0,1,1,1,1,0,0,0, done at t+11 with done_id=2, hit=1, hit_cnt=1.
- Miss: req[1]=1, data[1]=8'b1101_1011 -> done_id=1, hit=0, hit_cnt unchanged.
- Fairness: req=4'hF held, with each requester dropping its req on its gnt -> service order 0,1,2,3, done pulses 12 cycles apart.
- Tail hit: data=8'b0000_1111 -> hit=1, because the detector fires on the DRAIN sample.
- Mid-frame reset: assert rst during the fourth SHIFT cycle -> no done, busy=0 on the next cycle, hit_cnt=0. A new request is served normally afterwards.
